moore1_decoder: RTL and testbench
=================================

MOORE1_DECODER -- requirements
Module: moore1_decoder

Interface
REQ-001 SHALL have parameter LOCK_LEN, default 2, meaning the number of consecutive legal samples needed to assert lock (range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports code_a and code_b, inputs, 1 bit each: the state code {code_a,code_b} from the upstream Moore encoder (E0=00, E1=01, E2=10, E3=11).
REQ-005 SHALL have port err_clr, input, 1 bit: synchronous clear of the error counter.
REQ-006 SHALL have ports dec_a and dec_b, outputs, 1 bit each: registered one-cycle pulses for the recovered inA and inB events.
REQ-007 SHALL have port locked, output, 1 bit: the decoder is tracking a legal code stream.
REQ-008 SHALL have port err, output, 1 bit: registered one-cycle pulse for an illegal transition while locked.
REQ-009 SHALL have port err_cnt, output, 8 bits: the saturating illegal-transition count.

Function
REQ-010 SHALL sample {code_a,code_b} on every rising clk edge and compare it with the registered previous sample prev.
REQ-011 SHALL treat these transitions as legal inA (dec_a): E0->E1, E1->E0, E2->E3, E3->E2.
REQ-012 SHALL treat these transitions as legal inB (dec_b): E0->E3, E1->E2, E2->E1, E3->E0.
REQ-013 SHALL treat cur==prev as a legal hold, with no decoded pulse.
REQ-014 SHALL treat these transitions as illegal: E0->E2, E1->E3, E2->E0, E3->E1.
REQ-015 SHALL implement the control FSM states HUNT, CHECK and LOCKED.
REQ-016 In HUNT, SHALL capture the sample into prev, clear the lock counter, and go to CHECK.
REQ-017 In CHECK, a legal sample SHALL increment the lock counter; on reaching LOCK_LEN the FSM SHALL go to LOCKED; an illegal sample SHALL clear the counter and stay in CHECK, with no err pulse.
REQ-018 In LOCKED, an illegal sample SHALL pulse err for one cycle, increment err_cnt, and move to CHECK with the counter cleared.
REQ-019 SHALL load prev with the current sample on every edge outside reset.
REQ-020 SHALL emit dec_a/dec_b in CHECK and LOCKED only, one cycle after the sampling edge, and never both in the same cycle.
REQ-021 SHALL hold locked at 1 exactly while the FSM is in LOCKED, registered.
REQ-022 SHALL saturate err_cnt at 255.
REQ-023 SHALL give err_clr priority over a simultaneous error: err_cnt becomes 0 while err still pulses.

Reset
REQ-024 SHALL, on reset, immediately set dec_a=0, dec_b=0, err=0, locked=0, err_cnt=0, prev=E0, the lock counter to 0, and the FSM to HUNT, including when reset arrives mid-sequence.
REQ-025 SHALL resume in HUNT on the first rising edge after reset deasserts.

Configuration
REQ-026 SHALL provide the macro MOORE1_DEC_ERRCNT_EN.
REQ-027 With MOORE1_DEC_ERRCNT_EN defined, SHALL implement the err_cnt counter and err_clr as specified.
REQ-028 Without MOORE1_DEC_ERRCNT_EN, SHALL keep the ports, tie err_cnt to 0, and ignore err_clr, while err still pulses.

Structure
REQ-029 SHALL take the code constants E0..E3 and the decoder state encodings HUNT/CHECK/LOCKED from the shared package moore1_pkg, so the encoder and decoder share one encoding.
REQ-030 SHALL place the transition classification in the combinational sub-module moore1_edge_decode: (prev, cur) -> {is_a, is_b, illegal}.

Verification
REQ-031 Reset, then hold 00 for 3 edges (LOCK_LEN=2) -> locked=1 after the 3rd edge; dec_a=dec_b=err=0 throughout.
REQ-032 While locked at E0, drive E1, E2, E1, E1 -> dec_a, dec_b, dec_b pulses on consecutive cycles, then none; err=0.
REQ-033 While locked at E0, drive E2 -> err=1 for one cycle, err_cnt=1, locked=0; then E2, E2 -> locked=1 again.
REQ-034 Force 300 illegal jumps, relocking between them -> err_cnt=255 and stays at 255.
REQ-035 Illegal jump with err_clr=1 in the same cycle -> err=1 and err_cnt=0.
REQ-036 Assert reset between clock edges while locked with err_cnt=5 -> all outputs 0 before the next edge; the FSM restarts in HUNT.

Source files
------------

// File: rtl/moore1_pkg.sv
// Shared encoding for the moore1 encoder/decoder pair: state codes E0..E3,
// decoder FSM states, error-counter sizing and a saturating-increment helper.
package moore1_pkg;

    // Upstream Moore encoder state codes as seen on {code_a, code_b}
    typedef enum logic [1:0] {
        E0 = 2'b00,
        E1 = 2'b01,
        E2 = 2'b10,
        E3 = 2'b11
    } code_t;

    // Decoder control FSM states
    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        CHECK  = 2'b01,
        LOCKED = 2'b10
    } dec_state_t;

    localparam int unsigned ERR_CNT_W   = 8;
    localparam logic [7:0]  ERR_CNT_MAX = 8'hFF;

    // Increment an 8-bit count, holding at the maximum value
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == ERR_CNT_MAX) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/moore1_decoder_if.sv
// Bus bundle between the code source / result consumer and moore1_decoder.
// master: drives the code stream and err_clr, observes decoder results.
// slave : the decoder side.
interface moore1_decoder_if;
    import moore1_pkg::*;

    logic                 code_a;
    logic                 code_b;
    logic                 err_clr;
    logic                 dec_a;
    logic                 dec_b;
    logic                 locked;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output code_a, code_b, err_clr,
        input  dec_a, dec_b, locked, err, err_cnt
    );

    modport slave (
        input  code_a, code_b, err_clr,
        output dec_a, dec_b, locked, err, err_cnt
    );

endinterface

// File: rtl/moore1_edge_decode.sv
// Combinational classification of a (prev, cur) code pair.
// The code is Gray-like: flipping only the low bit is an inA event,
// flipping both bits is an inB event, flipping only the high bit is illegal,
// and no change is a hold.
module moore1_edge_decode
    import moore1_pkg::*;
(
    input  code_t prev_i,
    input  code_t cur_i,
    output logic  is_a,
    output logic  is_b,
    output logic  illegal
);

    logic [1:0] diff_s;

    // Classify the transition from the bit difference of the two codes
    always_comb begin
        diff_s  = prev_i ^ cur_i;
        is_a    = 1'b0;
        is_b    = 1'b0;
        illegal = 1'b0;
        case (diff_s)
            2'b00:   begin end
            2'b01:   is_a    = 1'b1;
            2'b11:   is_b    = 1'b1;
            2'b10:   illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/moore1_decoder.sv
// moore1_decoder: recovers inA/inB events from a Moore-encoded 2-bit code
// stream, tracks lock on a legal stream and counts illegal transitions.
// Optional feature macro: MOORE1_DEC_ERRCNT_EN -- when defined, err_cnt is a
// saturating illegal-transition counter cleared by err_clr; when undefined,
// err_cnt reads 0 and err_clr is ignored (err still pulses).
module moore1_decoder
    import moore1_pkg::*;
#(
    parameter int unsigned LOCK_LEN = 2
) (
    input  logic              clk,
    input  logic              reset,
    moore1_decoder_if.slave   bus
);

    localparam logic [3:0] LOCK_LEN_C = 4'(LOCK_LEN);

    code_t      cur_s;
    logic       is_a_s;
    logic       is_b_s;
    logic       illegal_s;
    logic       err_hit_s;
    logic [3:0] cnt_inc_s;

    dec_state_t state_q,    state_d;
    code_t      prev_q,     prev_d;
    logic [3:0] lock_cnt_q, lock_cnt_d;
    logic       dec_a_q,    dec_a_d;
    logic       dec_b_q,    dec_b_d;
    logic       err_q,      err_d;
    logic       locked_q,   locked_d;
    logic [7:0] err_cnt_q,  err_cnt_d;

    assign cur_s     = code_t'({bus.code_a, bus.code_b});
    assign cnt_inc_s = lock_cnt_q + 4'd1;

    moore1_edge_decode u_edge_decode (
        .prev_i  (prev_q),
        .cur_i   (cur_s),
        .is_a    (is_a_s),
        .is_b    (is_b_s),
        .illegal (illegal_s)
    );

    // Next-state, lock counter and output pulses for the HUNT/CHECK/LOCKED FSM
    always_comb begin
        state_d    = state_q;
        prev_d     = cur_s;
        lock_cnt_d = lock_cnt_q;
        dec_a_d    = 1'b0;
        dec_b_d    = 1'b0;
        err_d      = 1'b0;
        err_hit_s  = 1'b0;
        case (state_q)
            HUNT: begin
                lock_cnt_d = 4'd0;
                state_d    = CHECK;
            end
            CHECK: begin
                if (illegal_s) begin
                    lock_cnt_d = 4'd0;
                end else begin
                    dec_a_d    = is_a_s;
                    dec_b_d    = is_b_s;
                    lock_cnt_d = cnt_inc_s;
                    if (cnt_inc_s >= LOCK_LEN_C) begin
                        state_d = LOCKED;
                    end else begin
                        state_d = CHECK;
                    end
                end
            end
            LOCKED: begin
                if (illegal_s) begin
                    err_d      = 1'b1;
                    err_hit_s  = 1'b1;
                    lock_cnt_d = 4'd0;
                    state_d    = CHECK;
                end else begin
                    dec_a_d = is_a_s;
                    dec_b_d = is_b_s;
                end
            end
            default: begin
                lock_cnt_d = 4'd0;
                state_d    = HUNT;
            end
        endcase
        locked_d = (state_d == LOCKED);
    end

`ifdef MOORE1_DEC_ERRCNT_EN
    // Saturating error count; a clear wins over a same-cycle error
    always_comb begin
        if (bus.err_clr) begin
            err_cnt_d = 8'd0;
        end else if (err_hit_s) begin
            err_cnt_d = sat_inc8(err_cnt_q);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end
`else
    logic unused_err_clr_s;
    assign unused_err_clr_s = bus.err_clr;

    // Error counting disabled: count reads as zero
    always_comb begin
        err_cnt_d = 8'd0;
    end
`endif

    // State and registered outputs, asynchronously cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HUNT;
            prev_q     <= E0;
            lock_cnt_q <= 4'd0;
            dec_a_q    <= 1'b0;
            dec_b_q    <= 1'b0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            lock_cnt_q <= lock_cnt_d;
            dec_a_q    <= dec_a_d;
            dec_b_q    <= dec_b_d;
            err_q      <= err_d;
            locked_q   <= locked_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.dec_a   = dec_a_q;
    assign bus.dec_b   = dec_b_q;
    assign bus.err     = err_q;
    assign bus.locked  = locked_q;
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_moore1_decoder.sv
// Directed self-checking bench for moore1_decoder (LOCK_LEN = 2).
// Expected err_cnt follows MOORE1_DEC_ERRCNT_EN: the real count when defined,
// zero otherwise.
module tb_moore1_decoder;

`ifdef MOORE1_DEC_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    moore1_decoder_if bus ();

    moore1_decoder #(.LOCK_LEN(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_cnt(input int v);
        if (!CNT_EN) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic da, input logic db,
                           input logic lk, input logic er, input logic [7:0] cnt);
        chk({tag, ".dec_a"},   {7'd0, bus.dec_a},  {7'd0, da});
        chk({tag, ".dec_b"},   {7'd0, bus.dec_b},  {7'd0, db});
        chk({tag, ".locked"},  {7'd0, bus.locked}, {7'd0, lk});
        chk({tag, ".err"},     {7'd0, bus.err},    {7'd0, er});
        chk({tag, ".err_cnt"}, bus.err_cnt,        cnt);
    endtask

    // Drive one code sample, let one rising edge take it, then settle
    task automatic step(input logic [1:0] code, input logic clr);
        bus.code_a  = code[1];
        bus.code_b  = code[0];
        bus.err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] tgt;
        logic [1:0] at;
        n_vec = 0;
        n_err = 0;
        reset       = 1'b1;
        bus.code_a  = 1'b0;
        bus.code_b  = 1'b0;
        bus.err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        #3 reset = 1'b0;

        // Hold E0: HUNT, CHECK cnt=1, LOCKED on third edge
        step(2'b00, 1'b0); chk_out("hold1", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(2'b00, 1'b0); chk_out("hold2", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(2'b00, 1'b0); chk_out("hold3", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

        // E0->E1 inA, E1->E2 inB, E2->E1 inB, E1 hold, E1->E0 inA
        step(2'b01, 1'b0); chk_out("e0e1", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        step(2'b10, 1'b0); chk_out("e1e2", 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        step(2'b01, 1'b0); chk_out("e2e1", 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        step(2'b01, 1'b0); chk_out("e1e1", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        step(2'b00, 1'b0); chk_out("e1e0", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);

        // Illegal E0->E2 while locked, then relock on E2 holds
        step(2'b10, 1'b0); chk_out("ill1", 1'b0, 1'b0, 1'b0, 1'b1, exp_cnt(1));
        step(2'b10, 1'b0); chk_out("rel1", 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt(1));
        step(2'b10, 1'b0); chk_out("rel2", 1'b0, 1'b0, 1'b1, 1'b0, exp_cnt(1));

        // Illegal E2->E0 with err_clr in the same cycle
        step(2'b00, 1'b1); chk_out("clr_ill", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        step(2'b00, 1'b0); chk_out("clr_rel1", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(2'b00, 1'b0); chk_out("clr_rel2", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

        // 300 illegal jumps alternating E0<->E2, relocking between them
        at = 2'b00;
        for (int i = 0; i < 300; i++) begin
            tgt = at ^ 2'b10;
            step(tgt, 1'b0);
            chk("sat.err", {7'd0, bus.err}, 8'd1);
            chk("sat.cnt", bus.err_cnt, exp_cnt(i + 1));
            step(tgt, 1'b0);
            step(tgt, 1'b0);
            at = tgt;
        end
        chk_out("sat_end", 1'b0, 1'b0, 1'b1, 1'b0, exp_cnt(300));

        // Clear on a hold (no error), then build err_cnt to 5
        step(at, 1'b1); chk_out("clr_hold", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            tgt = at ^ 2'b10;
            step(tgt, 1'b0);
            step(tgt, 1'b0);
            step(tgt, 1'b0);
            at = tgt;
        end
        chk_out("pre_rst", 1'b0, 1'b0, 1'b1, 1'b0, exp_cnt(5));

        // Pulse pending on outputs, then asynchronous reset between edges
        tgt = at ^ 2'b01;
        step(tgt, 1'b0);
        chk_out("pre_rst_a", 1'b1, 1'b0, 1'b1, 1'b0, exp_cnt(5));
        #2 reset = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        chk_out("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        #3 reset = 1'b0;

        // Restart in HUNT: E3 captured silently (prev was E0), then
        // illegal E3->E1 in CHECK gives no err, then relock on E1
        step(2'b11, 1'b0); chk_out("hunt_e3", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(2'b01, 1'b0); chk_out("chk_ill", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(2'b01, 1'b0); chk_out("chk_h1", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(2'b01, 1'b0); chk_out("chk_h2", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

        // E1->E3 illegal while locked counts from the reset value
        step(2'b11, 1'b0); chk_out("post_ill", 1'b0, 1'b0, 1'b0, 1'b1, exp_cnt(1));
        // E3->E2 inA while in CHECK still decodes
        step(2'b10, 1'b0); chk_out("chk_a", 1'b1, 1'b0, 1'b0, 1'b0, exp_cnt(1));
        // E2->E1 inB reaches lock
        step(2'b01, 1'b0); chk_out("chk_b", 1'b0, 1'b1, 1'b1, 1'b0, exp_cnt(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
